// File: rtl/lsu_pkg.sv
// Shared load/store unit definitions: funct3 size codes, writeback source codes,
// FSM state encoding and small request-decoding helpers.
package lsu_pkg;

  // RV32I load size/sign codes
  localparam logic [2:0] Funct3Lb  = 3'b000;
  localparam logic [2:0] Funct3Lh  = 3'b001;
  localparam logic [2:0] Funct3Lw  = 3'b010;
  localparam logic [2:0] Funct3Lbu = 3'b100;
  localparam logic [2:0] Funct3Lhu = 3'b101;

  // RV32I store size codes
  localparam logic [2:0] Funct3Sb  = 3'b000;
  localparam logic [2:0] Funct3Sh  = 3'b001;
  localparam logic [2:0] Funct3Sw  = 3'b010;

  // Writeback source select codes shared with the rest of the pipeline
  localparam logic [1:0] WbSrcAlu  = 2'd0;
  localparam logic [1:0] WbSrcMem  = 2'd1;
  localparam logic [1:0] WbSrcPc4  = 2'd2;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWaitR,
    StResp
  } lsu_state_e;

  // Size/sign code is meaningful for this direction; unsigned variants exist only for loads.
  function automatic logic lsu_legal(input logic we, input logic [2:0] funct3);
    logic ok;
    case (funct3)
      Funct3Lb, Funct3Lh, Funct3Lw: ok = 1'b1;
      Funct3Lbu, Funct3Lhu:         ok = ~we;
      default:                      ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Half needs an even address, word needs a word-aligned address.
  function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      2'b01:   bad = addr_lo[0];
      2'b10:   bad = (addr_lo != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

  // Byte lane offset with offending low bits cleared, which forces natural alignment.
  function automatic logic [1:0] lsu_offset(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [1:0] off;
    case (size)
      2'b00:   off = addr_lo;
      2'b01:   off = {addr_lo[1], 1'b0};
      default: off = 2'b00;
    endcase
    return off;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the data memory bus: store byte enables and lane
// replication, and load lane extraction with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [31:0] shifted;

  // Store side: enables shifted to the addressed lanes, data replicated across all lanes
  always_comb begin
    be_o    = 4'b1111;
    wdata_o = wdata_i;
    case (funct3_i[1:0])
      2'b00: begin
        be_o    = 4'b0001 << off_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        be_o    = 4'b0011 << off_i;
        wdata_o = {2{wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Load side: bring the addressed lane down to bit 0, then extend
  always_comb begin
    shifted = rdata_i >> {off_i, 3'b000};
    case (funct3_i)
      Funct3Lb:  rdata_o = {{24{shifted[7]}}, shifted[7:0]};
      Funct3Lbu: rdata_o = {24'd0, shifted[7:0]};
      Funct3Lh:  rdata_o = {{16{shifted[15]}}, shifted[15:0]};
      Funct3Lhu: rdata_o = {16'd0, shifted[15:0]};
      default:   rdata_o = shifted;
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// Load/store unit between the execute stage and the data memory bus.
// One access in flight at a time: IDLE -> REQ -> (WAIT_R) -> RESP -> IDLE.
// Optional build macro LSU_MISALIGN_CHECK_EN: misaligned half/word accesses are
// rejected with rsp_err_o instead of being silently aligned.
module memory_access
  import lsu_pkg::*;
#(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned AWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [AWIDTH-1:0] req_addr_i,
  input  logic [DWIDTH-1:0] req_wdata_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [AWIDTH-1:0] mem_addr_o,
  output logic [DWIDTH-1:0] mem_wdata_o,
  output logic [3:0]        mem_be_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DWIDTH-1:0] mem_rdata_i,
  output logic              rsp_valid_o,
  output logic [DWIDTH-1:0] memory_data_o,
  output logic              rsp_err_o,
  output logic              stall_o
);

  lsu_state_e        state_q, state_d;
  logic              we_q, err_q;
  logic [2:0]        funct3_q;
  logic [1:0]        off_q;
  logic [AWIDTH-3:0] addr_q;
  logic [DWIDTH-1:0] wdata_q, rdata_q;

  logic              req_legal, accept, capture_load, in_req;
  logic [3:0]        al_be;
  logic [DWIDTH-1:0] al_wdata, al_rdata;

  // Request decode: funct3/direction legality, plus alignment when checking is built in
  always_comb begin
    req_legal = lsu_legal(req_we_i, req_funct3_i);
`ifdef LSU_MISALIGN_CHECK_EN
    if (lsu_misaligned(req_funct3_i[1:0], req_addr_i[1:0])) begin
      req_legal = 1'b0;
    end
`endif
  end

  assign accept = req_valid_i & req_ready_o;

  // Next-state: illegal requests skip the bus and go straight to the response
  always_comb begin
    state_d      = state_q;
    capture_load = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = req_legal ? StReq : StResp;
      end
      StReq: begin
        if (mem_gnt_i) begin
          if (we_q) begin
            state_d = StResp;
          end else if (mem_rvalid_i) begin
            state_d      = StResp;
            capture_load = 1'b1;
          end else begin
            state_d = StWaitR;
          end
        end
      end
      StWaitR: begin
        if (mem_rvalid_i) begin
          state_d      = StResp;
          capture_load = 1'b1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register; reset abandons any access in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Request capture on acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      funct3_q <= 3'b000;
      off_q    <= 2'b00;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else if (accept) begin
      we_q     <= req_we_i;
      err_q    <= ~req_legal;
      funct3_q <= req_funct3_i;
      off_q    <= lsu_offset(req_funct3_i[1:0], req_addr_i[1:0]);
      addr_q   <= req_addr_i[AWIDTH-1:2];
      wdata_q  <= req_wdata_i;
    end
  end

  // Load result register, written only when read data is returned
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            rdata_q <= '0;
    else if (capture_load) rdata_q <= al_rdata;
  end

  lsu_align u_lsu_align (
    .funct3_i (funct3_q),
    .off_i    (off_q),
    .wdata_i  (wdata_q),
    .rdata_i  (mem_rdata_i),
    .be_o     (al_be),
    .wdata_o  (al_wdata),
    .rdata_o  (al_rdata)
  );

  // Bus outputs come straight from captured registers, so they hold steady through REQ
  always_comb begin
    in_req      = (state_q == StReq);
    mem_req_o   = in_req;
    mem_we_o    = in_req & we_q;
    mem_addr_o  = in_req ? {addr_q, 2'b00} : '0;
    mem_be_o    = in_req ? al_be : 4'b0000;
    mem_wdata_o = in_req ? al_wdata : '0;
  end

  // Handshake and status outputs; stall is held low while reset is asserted
  always_comb begin
    req_ready_o   = (state_q == StIdle);
    rsp_valid_o   = (state_q == StResp);
    rsp_err_o     = (state_q == StResp) & err_q;
    memory_data_o = rdata_q;
    stall_o       = rst_n & (((state_q == StIdle) & req_valid_i & req_legal) |
                             (state_q == StReq) | (state_q == StWaitR));
  end

endmodule

// File: tb/tb_memory_access.sv
// Self-checking bench for memory_access: table of accesses with hand-computed
// expectations, a bus/response scoreboard, and hand-written reset sequences.
module tb_memory_access;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [2:0]  req_funct3_i = 3'b000;
  logic [31:0] req_addr_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        rsp_valid_o, rsp_err_o, stall_o;
  logic [31:0] memory_data_o;

  always #5 clk = ~clk;

  memory_access #(.DWIDTH(32), .AWIDTH(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_we_i      (req_we_i),
    .req_funct3_i  (req_funct3_i),
    .req_addr_i    (req_addr_i),
    .req_wdata_i   (req_wdata_i),
    .mem_req_o     (mem_req_o),
    .mem_we_o      (mem_we_o),
    .mem_addr_o    (mem_addr_o),
    .mem_wdata_o   (mem_wdata_o),
    .mem_be_o      (mem_be_o),
    .mem_gnt_i     (mem_gnt_i),
    .mem_rvalid_i  (mem_rvalid_i),
    .mem_rdata_i   (mem_rdata_i),
    .rsp_valid_o   (rsp_valid_o),
    .memory_data_o (memory_data_o),
    .rsp_err_o     (rsp_err_o),
    .stall_o       (stall_o)
  );

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          gnt_dly;   // REQ cycles before the grant cycle
    int          r_dly;     // cycles from grant to rvalid (0 = same cycle)
    logic        err;
    logic [31:0] data;      // memory_data_o expected at and after the response
    logic [3:0]  be;
    logic [31:0] maddr;
    logic [31:0] mwdata;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
  } bus_t;

  typedef struct {
    logic        err;
    logic [31:0] data;
  } rsp_t;

  bus_t bus_q[$];
  rsp_t rsp_q[$];
  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata, input int g,
                              input int r, input logic err, input logic [31:0] data,
                              input logic [3:0] be, input logic [31:0] maddr,
                              input logic [31:0] mwdata);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.gnt_dly = g; v.r_dly = r; v.err = err; v.data = data;
    v.be = be; v.maddr = maddr; v.mwdata = mwdata;
    return v;
  endfunction

  // Scoreboard: compare bus requests and responses against queued expectations
  always @(negedge clk) begin
    rsp_t r;
    if (rst_n) begin
      if (mem_req_o) begin
        if (bus_q.size() == 0) begin
          check("unexpected_mem_req", {31'd0, mem_req_o}, 32'd0);
        end else begin
          check("mem_addr", mem_addr_o, bus_q[0].addr);
          check("mem_be", {28'd0, mem_be_o}, {28'd0, bus_q[0].be});
          check("mem_we", {31'd0, mem_we_o}, {31'd0, bus_q[0].we});
          if (bus_q[0].we) check("mem_wdata", mem_wdata_o, bus_q[0].wdata);
          if (mem_gnt_i) void'(bus_q.pop_front());
        end
      end
      if (rsp_valid_o) begin
        if (rsp_q.size() == 0) begin
          check("unexpected_rsp", {31'd0, rsp_valid_o}, 32'd0);
        end else begin
          r = rsp_q.pop_front();
          check("rsp_err", {31'd0, rsp_err_o}, {31'd0, r.err});
          check("memory_data", memory_data_o, r.data);
        end
      end
    end
  end

  // Drive one access with a scripted memory, counting stall and response cycles
  task automatic run_access(input vec_t v, output int stalls, output int pulses,
                            output int rsp_cyc);
    int   g_cyc, r_cyc, last;
    logic legal;
    bus_t b;
    rsp_t rs;
    legal  = ~v.err;
    g_cyc  = 1 + v.gnt_dly;
    r_cyc  = g_cyc + (v.we ? 0 : v.r_dly);
    last   = (legal ? r_cyc + 1 : 1) + 3;
    stalls = 0;
    pulses = 0;
    rsp_cyc = -1;
    if (legal) begin
      b.addr = v.maddr; b.be = v.be; b.we = v.we; b.wdata = v.mwdata;
      bus_q.push_back(b);
    end
    rs.err = v.err; rs.data = v.data;
    rsp_q.push_back(rs);
    for (int c = 0; c <= last; c++) begin
      @(posedge clk); #1;
      req_valid_i  = (c == 0);
      req_we_i     = v.we;
      req_funct3_i = v.f3;
      req_addr_i   = v.addr;
      req_wdata_i  = v.wdata;
      mem_gnt_i    = legal && (c == g_cyc);
      mem_rvalid_i = legal && !v.we && (c == r_cyc);
      mem_rdata_i  = mem_rvalid_i ? v.rdata : 32'h5A5A_5A5A;
      @(negedge clk);
      if (stall_o) stalls++;
      if (rsp_valid_o) begin
        pulses++;
        rsp_cyc = c;
      end
    end
    check("rsp_outstanding", rsp_q.size(), 32'd0);
    check("bus_outstanding", bus_q.size(), 32'd0);
    rsp_q.delete();
    bus_q.delete();
  endtask

  initial begin
    int   stalls, pulses, rsp_cyc, exp_rsp;
    bus_t b;

    // Reset with a legal request pending: everything must stay quiet
    req_valid_i  = 1'b1;
    req_funct3_i = 3'b010;
    req_addr_i   = 32'h100;
    repeat (2) @(negedge clk);
    check("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we_o}, 32'd0);
    check("rst_mem_be", {28'd0, mem_be_o}, 32'd0);
    check("rst_mem_addr", mem_addr_o, 32'd0);
    check("rst_mem_wdata", mem_wdata_o, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
    check("rst_rsp_err", {31'd0, rsp_err_o}, 32'd0);
    check("rst_memory_data", memory_data_o, 32'd0);
    check("rst_stall", {31'd0, stall_o}, 32'd0);
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    rst_n       = 1'b1;

    //                we  f3      addr      wdata         rdata         g  r  err data          be    maddr     mwdata
    vecs.push_back(mk(0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 0, 2, 0, 32'hDEADBEEF, 4'hF, 32'h100, 32'h0));
    vecs.push_back(mk(0, 3'b000, 32'h103, 32'h0,        32'h80FF0000, 1, 1, 0, 32'hFFFFFF80, 4'h8, 32'h100, 32'h0));
    vecs.push_back(mk(0, 3'b100, 32'h103, 32'h0,        32'h80FF0000, 0, 3, 0, 32'h00000080, 4'h8, 32'h100, 32'h0));
    vecs.push_back(mk(1, 3'b001, 32'h102, 32'h00001234, 32'h0,        2, 0, 0, 32'h00000080, 4'hC, 32'h100, 32'h12341234));
    vecs.push_back(mk(0, 3'b001, 32'h000, 32'h0,        32'h00008001, 0, 0, 0, 32'hFFFF8001, 4'h3, 32'h000, 32'h0));
    vecs.push_back(mk(0, 3'b101, 32'h002, 32'h0,        32'h80017FFF, 0, 1, 0, 32'h00008001, 4'hC, 32'h000, 32'h0));
    vecs.push_back(mk(1, 3'b000, 32'h101, 32'hFFFFFFA5, 32'h0,        1, 0, 0, 32'h00008001, 4'h2, 32'h100, 32'hA5A5A5A5));
    vecs.push_back(mk(1, 3'b010, 32'h204, 32'hCAFEF00D, 32'h0,        2, 0, 0, 32'h00008001, 4'hF, 32'h204, 32'hCAFEF00D));
    vecs.push_back(mk(0, 3'b011, 32'h010, 32'h0,        32'h0,        0, 0, 1, 32'h00008001, 4'h0, 32'h0,   32'h0));
    vecs.push_back(mk(1, 3'b100, 32'h020, 32'h55,       32'h0,        0, 0, 1, 32'h00008001, 4'h0, 32'h0,   32'h0));
    vecs.push_back(mk(0, 3'b111, 32'h030, 32'h0,        32'h0,        0, 0, 1, 32'h00008001, 4'h0, 32'h0,   32'h0));
    vecs.push_back(mk(1, 3'b110, 32'h040, 32'h77,       32'h0,        0, 0, 1, 32'h00008001, 4'h0, 32'h0,   32'h0));
`ifdef LSU_MISALIGN_CHECK_EN
    vecs.push_back(mk(0, 3'b010, 32'h101, 32'h0,        32'h11223344, 0, 1, 1, 32'h00008001, 4'h0, 32'h0,   32'h0));
    vecs.push_back(mk(0, 3'b001, 32'h103, 32'h0,        32'hABCD1234, 1, 0, 1, 32'h00008001, 4'h0, 32'h0,   32'h0));
`else
    vecs.push_back(mk(0, 3'b010, 32'h101, 32'h0,        32'h11223344, 0, 1, 0, 32'h11223344, 4'hF, 32'h100, 32'h0));
    vecs.push_back(mk(0, 3'b001, 32'h103, 32'h0,        32'hABCD1234, 1, 0, 0, 32'hFFFFABCD, 4'hC, 32'h100, 32'h0));
`endif
    vecs.push_back(mk(0, 3'b000, 32'h102, 32'h0,        32'h007F0000, 0, 1, 0, 32'h0000007F, 4'h4, 32'h100, 32'h0));

    foreach (vecs[i]) begin
      run_access(vecs[i], stalls, pulses, rsp_cyc);
      if (vecs[i].err)     exp_rsp = 1;
      else if (vecs[i].we) exp_rsp = 2 + vecs[i].gnt_dly;
      else                 exp_rsp = 2 + vecs[i].gnt_dly + vecs[i].r_dly;
      check($sformatf("v%0d_rsp_pulses", i), pulses, 32'd1);
      check($sformatf("v%0d_rsp_cycle", i), rsp_cyc, exp_rsp);
      check($sformatf("v%0d_stall_cycles", i), stalls, vecs[i].err ? 0 : exp_rsp);
      check($sformatf("v%0d_data_hold", i), memory_data_o, vecs[i].data);
      check($sformatf("v%0d_ready_idle", i), {31'd0, req_ready_o}, 32'd1);
    end

    // Reset while waiting for read data; a late rvalid after release must be ignored
    b.addr = 32'h300; b.be = 4'hF; b.we = 1'b0; b.wdata = 32'h0;
    bus_q.push_back(b);
    @(posedge clk); #1;
    req_valid_i = 1'b1; req_we_i = 1'b0; req_funct3_i = 3'b010; req_addr_i = 32'h300;
    @(posedge clk); #1;
    req_valid_i = 1'b0; mem_gnt_i = 1'b1;
    @(posedge clk); #1;
    mem_gnt_i = 1'b0;
    @(negedge clk);
    check("waitr_stall", {31'd0, stall_o}, 32'd1);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("midrst_mem_req", {31'd0, mem_req_o}, 32'd0);
    check("midrst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
    check("midrst_req_ready", {31'd0, req_ready_o}, 32'd1);
    check("midrst_stall", {31'd0, stall_o}, 32'd0);
    check("midrst_memory_data", memory_data_o, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1357_9BDF;
    @(posedge clk); #1;
    mem_rvalid_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("late_rvalid_no_rsp", {31'd0, rsp_valid_o}, 32'd0);
      check("late_rvalid_no_req", {31'd0, mem_req_o}, 32'd0);
      check("late_rvalid_ready", {31'd0, req_ready_o}, 32'd1);
    end
    check("late_rvalid_data", memory_data_o, 32'd0);
    bus_q.delete();

    // Normal operation resumes after the abandoned access
    run_access(mk(0, 3'b010, 32'h40, 32'h0, 32'h0BADF00D, 0, 1, 0, 32'h0BADF00D, 4'hF, 32'h40,
                  32'h0), stalls, pulses, rsp_cyc);
    check("recover_rsp_pulses", pulses, 32'd1);
    check("recover_rsp_cycle", rsp_cyc, 32'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_access.md
MEMORY_ACCESS -- requirements
Module: memory_access

Interface
REQ-001 SHALL have parameter DWIDTH, default 32, data width (only 32 supported).
REQ-002 SHALL have parameter AWIDTH, default 32, address width.
REQ-003 SHALL have port clk, input, 1, sole clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have port req_valid_i, input, 1, execute stage presents a load/store.
REQ-006 SHALL have port req_ready_o, output, 1, block accepts a request this cycle.
REQ-007 SHALL have port req_we_i, input, 1: 1 = store, 0 = load.
REQ-008 SHALL have port req_funct3_i, input, 3, RV32I size/sign code.
REQ-009 SHALL have port req_addr_i, input, AWIDTH, byte address (ALU result).
REQ-010 SHALL have port req_wdata_i, input, DWIDTH, store data (rs2).
REQ-011 SHALL have ports mem_req_o (1), mem_we_o (1), mem_addr_o (AWIDTH, word-aligned), mem_wdata_o (DWIDTH, lane-shifted), mem_be_o (4), all outputs, data memory bus.
REQ-012 SHALL have ports mem_gnt_i (1), mem_rvalid_i (1), mem_rdata_i (DWIDTH), all inputs, memory grant and read return.
REQ-013 SHALL have port rsp_valid_o, output, 1, one-cycle completion pulse.
REQ-014 SHALL have port memory_data_o, output, DWIDTH, extended load data for writeback.
REQ-015 SHALL have port rsp_err_o, output, 1, access rejected, valid with rsp_valid_o.
REQ-016 SHALL have port stall_o, output, 1, pipeline must hold.

Function
REQ-017 SHALL implement FSM states IDLE, REQ, WAIT_R, RESP.
REQ-018 SHALL assert req_ready_o only in IDLE; request accepted when req_valid_i and req_ready_o both high.
REQ-019 SHALL, on acceptance of a legal request, register address/data/funct3/we and enter REQ.
REQ-020 SHALL hold mem_req_o high and all mem_* outputs stable in REQ until mem_gnt_i.
REQ-021 SHALL, on grant: store -> RESP; load -> WAIT_R; load with mem_rvalid_i in grant cycle -> RESP directly.
REQ-022 SHALL, in WAIT_R, capture mem_rdata_i when mem_rvalid_i and enter RESP.
REQ-023 SHALL, in RESP, pulse rsp_valid_o for exactly one cycle, then return to IDLE.
REQ-024 SHALL drive mem_be_o: byte 0001<<addr[1:0], half 0011<<addr[1:0], word 1111; mem_wdata_o replicates store data into addressed lanes.
REQ-025 SHALL extract loads: LB 000 / LH 001 sign-extend; LBU 100 / LHU 101 zero-extend; LW 010 whole word.
REQ-026 SHALL update memory_data_o only on load completion and hold it otherwise; stores leave it unchanged.
REQ-027 SHALL treat funct3 011/110/111 (any) and 100/101 on store as illegal: no bus access, IDLE -> RESP, rsp_err_o=1.
REQ-028 SHALL assert stall_o = (state != IDLE) or (req_valid_i and legal and not yet accepted in same cycle), deasserting in the RESP cycle.
REQ-029 SHALL never issue a new mem_req_o while an access is outstanding.

Reset
REQ-030 SHALL, while rst_n low, force IDLE, mem_req_o=0, mem_we_o=0, mem_be_o=0, mem_addr_o=0, mem_wdata_o=0, rsp_valid_o=0, rsp_err_o=0, memory_data_o=0, stall_o=0.
REQ-031 SHALL abandon any in-flight access on reset mid-operation; a late mem_rvalid_i after reset release in IDLE SHALL be ignored.

Configuration
REQ-032 SHALL, with LSU_MISALIGN_CHECK_EN defined, reject half accesses with addr[0]=1 and word accesses with addr[1:0]!=0 as in REQ-027 (rsp_err_o=1, no bus access).
REQ-033 SHALL, without LSU_MISALIGN_CHECK_EN, force alignment by clearing offending low address bits and never assert rsp_err_o for alignment.

Structure
REQ-034 SHALL take funct3 size codes (LB..LHU, SB..SW) and the FSM state enum from shared package lsu_pkg, alongside existing constants.svh WB_SRC codes.
REQ-035 SHALL place lane select/extension in combinational sub-module lsu_align, instantiated once.

Verification
REQ-036 SHALL cover: LW addr 0x100, gnt cycle 2, rvalid cycle 4, rdata 0xDEADBEEF -> memory_data_o=0xDEADBEEF, rsp_valid_o one pulse, stall_o high 4 cycles.
REQ-037 SHALL cover: LB addr 0x103, rdata 0x80FF_0000 -> memory_data_o=0xFFFFFF80; LBU same -> 0x00000080.
REQ-038 SHALL cover: SH addr 0x102 data 0x0000_1234 -> mem_be_o=1100, mem_wdata_o=0x1234_1234, mem_addr_o=0x100, memory_data_o unchanged.
REQ-039 SHALL cover: LW addr 0x101 -> with macro rsp_err_o=1 and mem_req_o never high; without macro mem_addr_o=0x100, rsp_err_o=0.
REQ-040 SHALL cover: rst_n low in WAIT_R, rvalid arrives after release -> mem_req_o=0, no rsp_valid_o, req_ready_o=1.
REQ-041 SHALL cover: gnt and rvalid same cycle, rdata 0x00008001 LH addr 0x0 -> memory_data_o=0xFFFF8001 two cycles after acceptance.
